// File: rtl/fpu_dp_divider_seq.sv
// Sequential IEEE-754 binary64 divider: restoring radix-2, one quotient bit per cycle,
// truncating result, start/busy/done handshake with fixed latency for every operand class.
module fpu_dp_divider_seq #(
    parameter int WIDTH = 64,
    parameter int QBITS = 54
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             invalid,
    output logic             div_zero,
    output logic             overflow
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [53:0]        rem_q, rem_d;
    logic [52:0]        mb_q, mb_d;
    logic [53:0]        quo_q, quo_d;
    logic               sign_q, sign_d;
    logic signed [12:0] exp_q, exp_d;
    logic               sp_inv_q, sp_inv_d;
    logic               sp_dz_q, sp_dz_d;
    logic               sp_inf_q, sp_inf_d;
    logic               sp_zero_q, sp_zero_d;
    logic [63:0]        pend_res_q, pend_res_d;
    logic [2:0]         pend_flg_q, pend_flg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [63:0]        result_q, result_d;
    logic               invalid_q, invalid_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;

    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic signed [12:0] exp_n;
    logic [51:0]        frac_n;

    always_comb begin
        a_nan  = (A[62:52] == 11'h7FF) && (A[51:0] != 52'd0);
        a_inf  = (A[62:52] == 11'h7FF) && (A[51:0] == 52'd0);
        a_zero = (A[62:52] == 11'h000);
        b_nan  = (B[62:52] == 11'h7FF) && (B[51:0] != 52'd0);
        b_inf  = (B[62:52] == 11'h7FF) && (B[51:0] == 52'd0);
        b_zero = (B[62:52] == 11'h000);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        quo_d      = quo_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        sp_inv_d   = sp_inv_q;
        sp_dz_d    = sp_dz_q;
        sp_inf_d   = sp_inf_q;
        sp_zero_d  = sp_zero_q;
        pend_res_d = pend_res_q;
        pend_flg_d = pend_flg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        invalid_d  = invalid_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        exp_n      = quo_q[53] ? exp_q : exp_q - 13'sd1;
        frac_n     = quo_q[53] ? quo_q[52:1] : quo_q[51:0];

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d    = S_DIV;
                    busy_d     = 1'b1;
                    cnt_d      = 6'(QBITS - 1);
                    rem_d      = {2'b01, A[51:0]};
                    mb_d       = {1'b1, B[51:0]};
                    quo_d      = 54'd0;
                    sign_d     = A[63] ^ B[63];
                    exp_d      = $signed({2'b00, A[62:52]}) - $signed({2'b00, B[62:52]}) + 13'sd1023;
                    // Special-case classes are resolved by priority at pack time.
                    sp_inv_d   = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
                    sp_dz_d    = !a_zero && !a_inf && !a_nan && b_zero;
                    sp_inf_d   = a_inf;
                    sp_zero_d  = a_zero | b_inf;
                    invalid_d  = 1'b0;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            S_DIV: begin
                if (rem_q >= {1'b0, mb_q}) begin
                    quo_d = {quo_q[52:0], 1'b1};
                    rem_d = (rem_q - {1'b0, mb_q}) << 1;
                end else begin
                    quo_d = {quo_q[52:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                state_d    = S_DONE;
                pend_flg_d = 3'b000;
                if (sp_inv_q) begin
                    pend_res_d = 64'h7FF8_0000_0000_0000;
                    pend_flg_d = 3'b100;
                end else if (sp_dz_q) begin
                    pend_res_d = {sign_q, 11'h7FF, 52'd0};
                    pend_flg_d = 3'b010;
                end else if (sp_inf_q) begin
                    pend_res_d = {sign_q, 11'h7FF, 52'd0};
                end else if (sp_zero_q) begin
                    pend_res_d = {sign_q, 63'd0};
                end else if (exp_n >= 13'sd2047) begin
                    pend_res_d = {sign_q, 11'h7FF, 52'd0};
                    pend_flg_d = 3'b001;
                end else if (exp_n <= 13'sd0) begin
                    pend_res_d = {sign_q, 63'd0};
                end else begin
                    pend_res_d = {sign_q, exp_n[10:0], frac_n};
                end
            end
            default: begin
                // Result and flags are published together with the done pulse.
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                result_d   = pend_res_q;
                invalid_d  = pend_flg_q[2];
                div_zero_d = pend_flg_q[1];
                overflow_d = pend_flg_q[0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            quo_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            sp_inv_q   <= 1'b0;
            sp_dz_q    <= 1'b0;
            sp_inf_q   <= 1'b0;
            sp_zero_q  <= 1'b0;
            pend_res_q <= '0;
            pend_flg_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            invalid_q  <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            quo_q      <= quo_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            sp_inv_q   <= sp_inv_d;
            sp_dz_q    <= sp_dz_d;
            sp_inf_q   <= sp_inf_d;
            sp_zero_q  <= sp_zero_d;
            pend_res_q <= pend_res_d;
            pend_flg_q <= pend_flg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            invalid_q  <= invalid_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign invalid  = invalid_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;
endmodule
